rat_controller: RTL and testbench

Sequencing FSM for the IntelligentRat datapath. Drives the position registers, direction counter, adder, maze memory, path stack and replay queue to run a depth-first search from (0,0) to (15,15), marking visited cells as walls and backtracking via the stack. On success it replays the found path one move per cycle through the queue; on exhaustion it reports failure.

---
 rtl/rat_controller_if.sv | 57 +++++
 rtl/rat_controller.sv | 176 +++++++++++++++++
 tb/tb_rat_controller.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rat_controller_if.sv
// Bundles the rat controller's command inputs, datapath status inputs and
// datapath control outputs. The master side is the controller; the slave
// side is the datapath plus whatever issues start/run.
interface rat_controller_if;
    // Commands and datapath status into the controller
    logic       start;
    logic       run;
    logic       co;
    logic       wall;
    logic       finish;
    logic       empty;
    logic       finishq;
    logic [1:0] counter_val;
    logic [1:0] pop_val;

    // Datapath controls out of the controller
    logic       rst_reg;
    logic       rst_counter;
    logic       rst_frontq;
    logic       ld_reg;
    logic       ld_counter;
    logic       ld_q;
    logic       inc_counter;
    logic       adder_sel;
    logic       inc_dec_sel;
    logic       x_sel;
    logic       y_sel;
    logic       pop;
    logic       push;
    logic       dequeue;
    logic       rd_mem;
    logic       wr_mem;
    logic       mem_din;
    logic [1:0] push_val;
    logic [1:0] counter_ld_val;

    // Status to the outside world
    logic       busy;
    logic       done;
    logic       fail;

    modport master (
        input  start, run, co, wall, finish, empty, finishq, counter_val, pop_val,
        output rst_reg, rst_counter, rst_frontq, ld_reg, ld_counter, ld_q,
               inc_counter, adder_sel, inc_dec_sel, x_sel, y_sel, pop, push,
               dequeue, rd_mem, wr_mem, mem_din, push_val, counter_ld_val,
               busy, done, fail
    );

    modport slave (
        output start, run, co, wall, finish, empty, finishq, counter_val, pop_val,
        input  rst_reg, rst_counter, rst_frontq, ld_reg, ld_counter, ld_q,
               inc_counter, adder_sel, inc_dec_sel, x_sel, y_sel, pop, push,
               dequeue, rd_mem, wr_mem, mem_din, push_val, counter_ld_val,
               busy, done, fail
    );
endinterface

// File: rtl/rat_controller.sv
// Sequencing FSM for the IntelligentRat maze solver. Runs a depth-first
// search from (0,0) to (15,15): each visited cell is marked as a wall, moves
// are pushed on the path stack, dead ends are undone by popping the stack
// and stepping back. A found path is copied to the replay queue and can be
// played back one move per cycle.
module rat_controller (
    input  logic             clk,
    input  logic             rst,
    rat_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_MARK,
        S_CHECK,
        S_NEXT,
        S_BACK,
        S_POP,
        S_SOLVED,
        S_REPLAY,
        S_FAIL
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] dirCtl;
    logic [1:0] revDir;

    // Direction code to {adder_sel, inc_dec_sel, x_sel, y_sel}:
    // bit0 picks the axis (0 = x, 1 = y), bit1 picks the sign (0 = +1, 1 = -1).
    function automatic logic [3:0] decodeDir(input logic [1:0] d);
        return {~d[0], ~d[1], ~d[0], d[0]};
    endfunction

    // Stepping back out of a dead end is the move opposite to the one pushed.
    assign revDir = {~bus.pop_val[1], bus.pop_val[0]};

    // State register; reset drops straight to IDLE so all outputs go low at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and every datapath control, all defaulted to 0 first
    always_comb begin
        state_d            = state_q;
        dirCtl             = 4'b0000;
        bus.rst_reg        = 1'b0;
        bus.rst_counter    = 1'b0;
        bus.rst_frontq     = 1'b0;
        bus.ld_reg         = 1'b0;
        bus.ld_counter     = 1'b0;
        bus.ld_q           = 1'b0;
        bus.inc_counter    = 1'b0;
        bus.pop            = 1'b0;
        bus.push           = 1'b0;
        bus.dequeue        = 1'b0;
        bus.rd_mem         = 1'b0;
        bus.wr_mem         = 1'b0;
        bus.mem_din        = 1'b0;
        bus.push_val       = 2'b00;
        bus.counter_ld_val = 2'b00;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.fail           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_INIT;
                end
            end

            S_INIT: begin
                bus.busy        = 1'b1;
                bus.rst_reg     = 1'b1;
                bus.rst_counter = 1'b1;
                bus.rst_frontq  = 1'b1;
                state_d         = S_MARK;
            end

            S_MARK: begin
                bus.busy        = 1'b1;
                bus.wr_mem      = 1'b1;
                bus.mem_din     = 1'b1;
                bus.rst_counter = 1'b1;
                if (bus.finish) begin
                    bus.ld_q = 1'b1;
                    state_d  = S_SOLVED;
                end else begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                bus.busy   = 1'b1;
                bus.rd_mem = 1'b1;
                dirCtl     = decodeDir(bus.counter_val);
                if (!bus.wall) begin
                    bus.ld_reg   = 1'b1;
                    bus.push     = 1'b1;
                    bus.push_val = bus.counter_val;
                    state_d      = S_MARK;
                end else begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                bus.busy = 1'b1;
                if (!bus.co) begin
                    bus.inc_counter = 1'b1;
                    state_d         = S_CHECK;
                end else begin
                    state_d = S_BACK;
                end
            end

            S_BACK: begin
                bus.busy = 1'b1;
                if (bus.empty) begin
                    state_d = S_FAIL;
                end else begin
                    state_d = S_POP;
                end
            end

            S_POP: begin
                bus.busy           = 1'b1;
                dirCtl             = decodeDir(revDir);
                bus.ld_reg         = 1'b1;
                bus.pop            = 1'b1;
                bus.ld_counter     = 1'b1;
                bus.counter_ld_val = bus.pop_val;
                state_d            = S_NEXT;
            end

            S_SOLVED: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    state_d = S_INIT;
                end else if (bus.run) begin
                    state_d = S_REPLAY;
                end
            end

            S_REPLAY: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                if (!bus.finishq) begin
                    bus.dequeue = 1'b1;
                end else begin
                    state_d = S_SOLVED;
                end
            end

            S_FAIL: begin
                bus.fail = 1'b1;
                if (bus.start) begin
                    state_d = S_INIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        {bus.adder_sel, bus.inc_dec_sel, bus.x_sel, bus.y_sel} = dirCtl;
    end

endmodule

// File: tb/tb_rat_controller.sv
// Testbench for rat_controller. A behavioural datapath (position, counter,
// maze memory, path stack, replay queue) closes the loop around the FSM;
// expected move sequences are queued up front and compared against what
// the controller actually pushes and replays.
module tb_rat_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rat_controller_if rif ();

    rat_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (rif)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural datapath state
    logic       mazeQ    [256];
    logic       mazeInit [256];
    logic       loadMaze = 1'b0;
    int         px = 0;
    int         py = 0;
    int         nx;
    int         ny;
    int         sp = 0;
    int         qlen = 0;
    int         front = 0;
    logic [1:0] cnt = 2'b00;
    logic [1:0] stk [256];
    logic [1:0] rq  [256];
    logic [7:0] nIdx;
    logic [1:0] qOut;

    // Observation logs filled by the monitor
    logic [1:0] pushLog [$];
    logic [2:0] popLog  [$];
    logic [1:0] deqLog  [$];
    int         checkCnt = 0;
    int         ldqCnt = 0;

    logic [1:0] expQ [$];

    // Neighbour address selected by the controller's adder controls
    always_comb begin
        nx = px;
        ny = py;
        if (rif.x_sel) nx = rif.inc_dec_sel ? px + 1 : px - 1;
        if (rif.y_sel) ny = rif.inc_dec_sel ? py + 1 : py - 1;
    end

    assign nIdx            = 8'(ny * 16 + nx);
    assign rif.wall        = (nx < 0 || nx > 15 || ny < 0 || ny > 15) ? 1'b1 : mazeQ[nIdx];
    assign rif.co          = (cnt == 2'd3);
    assign rif.counter_val = cnt;
    assign rif.finish      = (px == 15 && py == 15);
    assign rif.empty       = (sp == 0);
    assign rif.pop_val     = (sp > 0) ? stk[8'(sp - 1)] : 2'b00;
    assign rif.finishq     = (front >= qlen);
    assign qOut            = rq[8'(front)];

    // Clocked datapath model driven by the controller outputs
    always @(posedge clk) begin
        if (loadMaze) begin
            for (int i = 0; i < 256; i++) mazeQ[i] <= mazeInit[i];
        end else if (rif.wr_mem) begin
            mazeQ[8'(py * 16 + px)] <= rif.mem_din;
        end
        if (rif.rst_reg) begin
            px <= 0;
            py <= 0;
        end else if (rif.ld_reg) begin
            px <= nx;
            py <= ny;
        end
        if (rif.rst_counter)      cnt <= 2'b00;
        else if (rif.ld_counter)  cnt <= rif.counter_ld_val;
        else if (rif.inc_counter) cnt <= cnt + 2'd1;
        if (rif.rst_frontq) begin
            sp    <= 0;
            qlen  <= 0;
            front <= 0;
        end else begin
            if (rif.push) begin
                stk[8'(sp)] <= rif.push_val;
                sp          <= sp + 1;
            end else if (rif.pop && sp > 0) begin
                sp <= sp - 1;
            end
            if (rif.ld_q) begin
                for (int j = 0; j < 256; j++) rq[j] <= stk[j];
                qlen  <= sp;
                front <= 0;
            end else if (rif.dequeue && front < qlen) begin
                front <= front + 1;
            end
        end
    end

    // Monitor: records pushes, pops, replayed moves and pulse counts
    always @(negedge clk) begin
        if (!rst) begin
            if (rif.push)    pushLog.push_back(rif.push_val);
            if (rif.pop)     popLog.push_back({rif.ld_counter, rif.counter_ld_val});
            if (rif.dequeue) deqLog.push_back(qOut);
            if (rif.rd_mem)  checkCnt <= checkCnt + 1;
            if (rif.ld_q)    ldqCnt <= ldqCnt + 1;
        end
    end

    function automatic logic [23:0] outVec();
        return {rif.rst_reg, rif.rst_counter, rif.rst_frontq, rif.ld_reg,
                rif.ld_counter, rif.ld_q, rif.inc_counter, rif.adder_sel,
                rif.inc_dec_sel, rif.x_sel, rif.y_sel, rif.pop, rif.push,
                rif.dequeue, rif.rd_mem, rif.wr_mem, rif.mem_din,
                rif.push_val, rif.counter_ld_val, rif.busy, rif.done, rif.fail};
    endfunction

    task automatic prepMaze(input int nWalls, input int w0x, input int w0y,
                            input int w1x, input int w1y);
        for (int i = 0; i < 256; i++) mazeInit[i] = 1'b0;
        if (nWalls > 0) mazeInit[w0y * 16 + w0x] = 1'b1;
        if (nWalls > 1) mazeInit[w1y * 16 + w1x] = 1'b1;
        @(negedge clk);
        loadMaze = 1'b1;
        @(negedge clk);
        loadMaze = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        rif.start = 1'b1;
        @(negedge clk);
        rif.start = 1'b0;
    endtask

    task automatic pulseRun();
        @(negedge clk);
        rif.run = 1'b1;
        @(negedge clk);
        rif.run = 1'b0;
    endtask

    task automatic waitEnd(input int maxCycles, output bit timedOut);
        timedOut = 1'b1;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            #1;
            if (!rif.busy && (rif.done || rif.fail)) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rif.start = 1'b0;
        rif.run   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outVec() !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", outVec(), 24'h0);
        end
        rst = 1'b0;
        pulseRun();
        @(negedge clk);
        #1;
        checks++;
        if (outVec() !== 24'h0) begin
            errors++;
            $display("[TB] FAIL run_in_idle: got %h expected %h", outVec(), 24'h0);
        end
    endtask

    task automatic test_reset_mid_search();
        bit found;
        prepMaze(0, 0, 0, 0, 0);
        pulseStart();
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (rif.rd_mem && !rif.wall) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL reach_check: got no CHECK expected CHECK within 50 cycles");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outVec() !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_search: got %h expected %h", outVec(), 24'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (outVec() !== 24'h0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %h expected %h", outVec(), 24'h0);
        end
    endtask

    task automatic test_open_maze();
        int         p0, q0, c0, l0;
        bit         timedOut;
        logic [1:0] exp, got;
        prepMaze(0, 0, 0, 0, 0);
        expQ.delete();
        for (int i = 0; i < 15; i++) expQ.push_back(2'b00);
        for (int i = 0; i < 15; i++) expQ.push_back(2'b01);
        p0 = pushLog.size();
        q0 = popLog.size();
        c0 = checkCnt;
        l0 = ldqCnt;
        pulseStart();
        timedOut = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rif.start = (c == 10);
            #1;
            if (!rif.busy && (rif.done || rif.fail)) begin
                timedOut = 1'b0;
                break;
            end
        end
        rif.start = 1'b0;
        checks++;
        if (timedOut) begin
            errors++;
            $display("[TB] FAIL open_timeout: got no end expected done within 2000 cycles");
        end
        checks++;
        if (pushLog.size() - p0 !== 30) begin
            errors++;
            $display("[TB] FAIL open_push_count: got %0d expected 30", pushLog.size() - p0);
        end
        for (int i = 0; i < 30; i++) begin
            exp = expQ.pop_front();
            got = (p0 + i < pushLog.size()) ? pushLog[p0 + i] : 2'bxx;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL open_push[%0d]: got %b expected %b", i, got, exp);
            end
        end
        checks++;
        if (popLog.size() - q0 !== 0) begin
            errors++;
            $display("[TB] FAIL open_pops: got %0d expected 0", popLog.size() - q0);
        end
        checks++;
        if (checkCnt - c0 !== 45) begin
            errors++;
            $display("[TB] FAIL open_checks: got %0d expected 45", checkCnt - c0);
        end
        checks++;
        if (ldqCnt - l0 !== 1) begin
            errors++;
            $display("[TB] FAIL open_ld_q: got %0d expected 1", ldqCnt - l0);
        end
        checks++;
        if ({rif.done, rif.fail, rif.busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL open_status: got %b expected 100", {rif.done, rif.fail, rif.busy});
        end
    endtask

    task automatic test_replay();
        int         d0;
        bit         timedOut;
        logic [1:0] exp, got;
        expQ.delete();
        for (int i = 0; i < 15; i++) expQ.push_back(2'b00);
        for (int i = 0; i < 15; i++) expQ.push_back(2'b01);
        d0 = deqLog.size();
        pulseRun();
        timedOut = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (!rif.busy) begin
                timedOut = 1'b0;
                break;
            end
        end
        checks++;
        if (timedOut) begin
            errors++;
            $display("[TB] FAIL replay_timeout: got busy expected SOLVED within 200 cycles");
        end
        checks++;
        if (deqLog.size() - d0 !== 30) begin
            errors++;
            $display("[TB] FAIL replay_count: got %0d expected 30", deqLog.size() - d0);
        end
        for (int i = 0; i < 30; i++) begin
            exp = expQ.pop_front();
            got = (d0 + i < deqLog.size()) ? deqLog[d0 + i] : 2'bxx;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL replay_q_out[%0d]: got %b expected %b", i, got, exp);
            end
        end
        checks++;
        if ({rif.done, rif.busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL replay_status: got %b expected 10", {rif.done, rif.busy});
        end
    endtask

    task automatic test_start_in_solved();
        int p0, c0, d0;
        bit timedOut;
        prepMaze(2, 1, 0, 0, 1);
        p0 = pushLog.size();
        c0 = checkCnt;
        d0 = deqLog.size();
        @(negedge clk);
        rif.start = 1'b1;
        rif.run   = 1'b1;
        @(negedge clk);
        rif.start = 1'b0;
        rif.run   = 1'b0;
        #1;
        checks++;
        if ({rif.done, rif.busy, rif.dequeue} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL start_wins: got %b expected 010", {rif.done, rif.busy, rif.dequeue});
        end
        waitEnd(200, timedOut);
        checks++;
        if (timedOut) begin
            errors++;
            $display("[TB] FAIL boxed_timeout: got no end expected fail within 200 cycles");
        end
        checks++;
        if ({rif.fail, rif.done, rif.busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL boxed_status: got %b expected 100", {rif.fail, rif.done, rif.busy});
        end
        checks++;
        if (pushLog.size() - p0 !== 0) begin
            errors++;
            $display("[TB] FAIL boxed_pushes: got %0d expected 0", pushLog.size() - p0);
        end
        checks++;
        if (checkCnt - c0 !== 4) begin
            errors++;
            $display("[TB] FAIL boxed_checks: got %0d expected 4", checkCnt - c0);
        end
        checks++;
        if (deqLog.size() - d0 !== 0) begin
            errors++;
            $display("[TB] FAIL boxed_dequeues: got %0d expected 0", deqLog.size() - d0);
        end
    endtask

    task automatic test_ignore_inputs();
        bit timedOut;
        pulseRun();
        @(negedge clk);
        #1;
        checks++;
        if ({rif.fail, rif.busy, rif.dequeue} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL run_in_fail: got %b expected 100", {rif.fail, rif.busy, rif.dequeue});
        end
        pulseStart();
        #1;
        checks++;
        if ({rif.fail, rif.busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL start_in_fail: got %b expected 01", {rif.fail, rif.busy});
        end
        waitEnd(200, timedOut);
        checks++;
        if (timedOut || rif.fail !== 1'b1) begin
            errors++;
            $display("[TB] FAIL refail: got fail=%b timeout=%0d expected fail=1 timeout=0", rif.fail, timedOut);
        end
    endtask

    task automatic test_dead_end();
        int         p0, q0;
        bit         timedOut;
        logic [1:0] exp, got;
        prepMaze(2, 2, 0, 1, 1);
        expQ.delete();
        expQ.push_back(2'b00);
        expQ.push_back(2'b01);
        expQ.push_back(2'b01);
        for (int i = 0; i < 15; i++) expQ.push_back(2'b00);
        for (int i = 0; i < 13; i++) expQ.push_back(2'b01);
        p0 = pushLog.size();
        q0 = popLog.size();
        pulseStart();
        waitEnd(3000, timedOut);
        checks++;
        if (timedOut) begin
            errors++;
            $display("[TB] FAIL dead_end_timeout: got no end expected done within 3000 cycles");
        end
        checks++;
        if (pushLog.size() - p0 !== 31) begin
            errors++;
            $display("[TB] FAIL dead_end_push_count: got %0d expected 31", pushLog.size() - p0);
        end
        for (int i = 0; i < 31; i++) begin
            exp = expQ.pop_front();
            got = (p0 + i < pushLog.size()) ? pushLog[p0 + i] : 2'bxx;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL dead_end_push[%0d]: got %b expected %b", i, got, exp);
            end
        end
        checks++;
        if (popLog.size() - q0 !== 1) begin
            errors++;
            $display("[TB] FAIL dead_end_pops: got %0d expected 1", popLog.size() - q0);
        end
        checks++;
        if (popLog.size() <= q0 || popLog[q0] !== 3'b100) begin
            errors++;
            $display("[TB] FAIL dead_end_pop_load: got %b expected 100",
                     (popLog.size() > q0) ? popLog[q0] : 3'bxxx);
        end
        checks++;
        if ({rif.done, rif.fail} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL dead_end_status: got %b expected 10", {rif.done, rif.fail});
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_reset_mid_search();
        test_open_maze();
        test_replay();
        test_start_in_solved();
        test_ignore_inputs();
        test_dead_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a scenario wedges somewhere unbounded
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 1000000 time units");
        $fatal(1);
    end

endmodule
